// File: rtl/line_scan_ctrl.sv
// Bit-serial sequencer for a 25-bit line store: load, first read, 24-step MSB-first scan, done pulse.
// Optional `LINE_SCAN_PARITY_EN adds a running XOR of the sampled bits on output `parity`.
module line_scan_ctrl #(
  parameter int size    = 5,
  parameter int memsize = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [memsize-1:0] line_in,
  input  logic               fill_in,
  input  logic               mem_out,
  output logic               ready,
  output logic               init,
  output logic [memsize-1:0] line,
  output logic [size-1:0]    index,
  output logic               read,
  output logic               write,
  output logic               firstread,
  output logic               val,
  output logic [memsize-1:0] result,
  output logic               done
`ifdef LINE_SCAN_PARITY_EN
  ,
  output logic               parity
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FIRST = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [size-1:0] LAST_IDX = size'(memsize - 1);

  logic [2:0]      state;
  logic [size-1:0] bit_sel;
  logic            sample;

  // Store index k carries line bit (memsize-1-k); FIRST (index 0) fills the MSB.
  assign bit_sel = LAST_IDX - index;
  assign sample  = (state == S_FIRST) || (state == S_SCAN);

  // Strobes are pure state decodes, so none can follow mem_out combinationally.
  assign ready     = (state == S_IDLE);
  assign init      = (state == S_LOAD);
  assign firstread = (state == S_FIRST);
  assign read      = (state == S_SCAN);
  assign write     = (state == S_SCAN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      index  <= '0;
      line   <= '0;
      val    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          index <= '0;
          if (start) begin
            line   <= line_in;
            val    <= fill_in;
            result <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD:  state <= S_FIRST;
        S_FIRST: begin
          index <= size'(1);
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (index == LAST_IDX) begin
            index <= '0;
            state <= S_DONE;
          end else begin
            index <= index + size'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (sample) result[bit_sel] <= mem_out;
    end
  end

`ifdef LINE_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)                         parity <= 1'b0;
    else if (state == S_IDLE && start) parity <= 1'b0;
    else if (sample)                 parity <= parity ^ mem_out;
  end
`endif

endmodule
